// File: rtl/nibble_packer.sv
// nibble_packer: packs a 4-bit nibble stream MSN-first into words and buffers
// completed words in a small show-ahead FIFO with a valid/ready output side.
module nibble_packer #(
  parameter int NIB_PER_WORD = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_L,
  input  logic [3:0]                NIB_IN,
  input  logic                      NIB_VALID,
  input  logic                      ALIGN,
  output logic [4*NIB_PER_WORD-1:0] WORD_OUT,
  output logic                      WORD_VALID,
  input  logic                      WORD_READY,
  output logic [ADDR_W:0]           LEVEL,
  output logic                      OVERFLOW
);

  localparam int WORD_W = 4 * NIB_PER_WORD;
  localparam int CNT_W  = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
  localparam int LVL_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_NIB   = CNT_W'(NIB_PER_WORD - 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]  packCnt_q, packCnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              store;
  logic [WORD_W-1:0] assembled;

  always_comb begin
    accept    = NIB_VALID && !ALIGN;
    push      = accept && (packCnt_q == LAST_NIB);
    // The completing nibble is merged combinationally so the pushed word includes it.
    assembled = {shift_q[WORD_W-5:0], NIB_IN};
    pop       = (level_q != '0) && WORD_READY;
    full      = (level_q == FULL_LEVEL);
    store     = push && (!full || pop);

    packCnt_d = packCnt_q;
    shift_d   = shift_q;
    if (ALIGN) begin
      packCnt_d = '0;
      shift_d   = '0;
    end else if (accept) begin
      if (push) begin
        packCnt_d = '0;
        shift_d   = '0;
      end else begin
        packCnt_d = packCnt_q + CNT_W'(1);
        shift_d   = assembled;
      end
    end

    wrPtr_d = store ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
    rdPtr_d = pop   ? rdPtr_q + ADDR_W'(1) : rdPtr_q;

    level_d = level_q;
    case ({store, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q || (push && full && !pop);
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      packCnt_q <= '0;
      shift_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      packCnt_q <= packCnt_d;
      shift_q   <= shift_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      if (store) begin
        mem_q[wrPtr_q] <= assembled;
      end
    end
  end

  assign WORD_OUT   = mem_q[rdPtr_q];
  assign WORD_VALID = (level_q != '0);
  assign LEVEL      = level_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed scenarios plus randomized traffic checked against
// a queue-based reference model of packing and FIFO buffering.
module tb_nibble_packer;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic [3:0]  NIB_IN = '0;
  logic        NIB_VALID = 1'b0;
  logic        ALIGN = 1'b0;
  logic        WORD_READY = 1'b0;
  logic [31:0] WORD_OUT;
  logic        WORD_VALID;
  logic [2:0]  LEVEL;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelWords[$];
  logic [3:0]  modelNibs[$];
  bit          modelOvf = 1'b0;

  nibble_packer #(.NIB_PER_WORD(8), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .NIB_IN(NIB_IN), .NIB_VALID(NIB_VALID),
    .ALIGN(ALIGN), .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID),
    .WORD_READY(WORD_READY), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, advance the reference model, then settle 1ns past the edge.
  task automatic applyStimulus(input bit v, input logic [3:0] n, input bit a, input bit r);
    bit          popNow;
    bit          pushNow;
    logic [31:0] w;
    NIB_VALID = v; NIB_IN = n; ALIGN = a; WORD_READY = r;
    popNow  = (modelWords.size() != 0) && r;
    pushNow = 1'b0;
    w       = '0;
    if (a) modelNibs.delete();
    else if (v) begin
      modelNibs.push_back(n);
      if (modelNibs.size() == 8) begin
        foreach (modelNibs[i]) w += 32'(modelNibs[i]) << (4 * (7 - i));
        pushNow = 1'b1;
        modelNibs.delete();
      end
    end
    if (popNow) void'(modelWords.pop_front());
    if (pushNow) begin
      if (modelWords.size() < 4) modelWords.push_back(w);
      else modelOvf = 1'b1;
    end
    @(posedge CLK);
    #1;
    NIB_VALID = 1'b0; ALIGN = 1'b0; WORD_READY = 1'b0;
  endtask

  task automatic feedWord(input logic [31:0] w, input bit readyOnLast);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, w[4*i +: 4], 1'b0, readyOnLast && (i == 0));
  endtask

  task automatic applyReset();
    RESET_L = 1'b0;
    #7;
    RESET_L = 1'b1;
    modelWords.delete(); modelNibs.delete(); modelOvf = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks += 4;
    if (WORD_OUT !== 32'h0) begin errors++; $display("[TB] FAIL reset_word got %h want 00000000", WORD_OUT); end
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", WORD_VALID); end
    if (LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", LEVEL); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", OVERFLOW); end
    applyReset();
  endtask

  task automatic test_basic_pack();
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    checks++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b want 0", WORD_VALID); end
    applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
    checks += 3;
    if (WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", WORD_VALID); end
    if (WORD_OUT !== 32'h12345678) begin errors++; $display("[TB] FAIL basic_word got %h want 12345678", WORD_OUT); end
    if (LEVEL !== 3'd1) begin errors++; $display("[TB] FAIL basic_level got %0d want 1", LEVEL); end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL basic_drain_level got %0d want 0", LEVEL); end
  endtask

  task automatic test_gaps_handshake();
    logic [31:0] pattern;
    pattern = 32'hDF00ABCE;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, pattern[4*i +: 4], 1'b0, 1'b0);
      if (i != 0) begin
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0);
      end
    end
    checks += 2;
    if (WORD_VALID !== 1'b1) begin errors++; $display("[TB] FAIL gaps_valid got %b want 1", WORD_VALID); end
    if (WORD_OUT !== 32'hDF00ABCE) begin errors++; $display("[TB] FAIL gaps_word got %h want DF00ABCE", WORD_OUT); end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checks += 2;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL gaps_pop_valid got %b want 0", WORD_VALID); end
    if (LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL gaps_pop_level got %0d want 0", LEVEL); end
  endtask

  task automatic test_fill_overflow();
    applyReset();
    for (int k = 1; k <= 4; k++) feedWord(32'h11111111 * k, 1'b0);
    checks += 2;
    if (LEVEL !== 3'd4) begin errors++; $display("[TB] FAIL fill_level got %0d want 4", LEVEL); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf_early got %b want 0", OVERFLOW); end
    feedWord(32'h55555555, 1'b0);
    checks += 2;
    if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL fill_ovf got %b want 1", OVERFLOW); end
    if (LEVEL !== 3'd4) begin errors++; $display("[TB] FAIL fill_ovf_level got %0d want 4", LEVEL); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (WORD_OUT !== 32'h11111111 * k) begin errors++; $display("[TB] FAIL drain_word%0d got %h want %h", k, WORD_OUT, 32'h11111111 * k); end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    end
    checks += 2;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %b want 0", WORD_VALID); end
    if (OVERFLOW !== 1'b1) begin errors++; $display("[TB] FAIL drain_ovf_sticky got %b want 1", OVERFLOW); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] expectOrder[4];
    expectOrder = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h66666666};
    applyReset();
    for (int k = 1; k <= 4; k++) feedWord(32'h11111111 * k, 1'b0);
    feedWord(32'h66666666, 1'b1);
    checks += 3;
    if (LEVEL !== 3'd4) begin errors++; $display("[TB] FAIL pushpop_level got %0d want 4", LEVEL); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_ovf got %b want 0", OVERFLOW); end
    if (WORD_OUT !== 32'h22222222) begin errors++; $display("[TB] FAIL pushpop_head got %h want 22222222", WORD_OUT); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (WORD_OUT !== expectOrder[k]) begin errors++; $display("[TB] FAIL pushpop_drain%0d got %h want %h", k, WORD_OUT, expectOrder[k]); end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    end
    checks++;
    if (LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL pushpop_end_level got %0d want 0", LEVEL); end
  endtask

  task automatic test_align();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    checks += 2;
    if (LEVEL !== 3'd1) begin errors++; $display("[TB] FAIL align_level got %0d want 1", LEVEL); end
    if (WORD_OUT !== 32'h01234567) begin errors++; $display("[TB] FAIL align_word got %h want 01234567", WORD_OUT); end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL align_single got %b want 0", WORD_VALID); end
  endtask

  task automatic test_mid_reset();
    feedWord(32'hA1A1A1A1, 1'b0);
    feedWord(32'hB2B2B2B2, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 3'd2) begin errors++; $display("[TB] FAIL midrst_pre_level got %0d want 2", LEVEL); end
    #2;
    RESET_L = 1'b0;
    #1;
    checks += 4;
    if (WORD_OUT !== 32'h0) begin errors++; $display("[TB] FAIL midrst_word got %h want 00000000", WORD_OUT); end
    if (WORD_VALID !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", WORD_VALID); end
    if (LEVEL !== 3'd0) begin errors++; $display("[TB] FAIL midrst_level got %0d want 0", LEVEL); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovf got %b want 0", OVERFLOW); end
    #2;
    RESET_L = 1'b1;
    modelWords.delete(); modelNibs.delete(); modelOvf = 1'b0;
    feedWord(32'hFFFFFFFF, 1'b0);
    checks += 2;
    if (WORD_OUT !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL midrst_word_after got %h want FFFFFFFF", WORD_OUT); end
    if (LEVEL !== 3'd1) begin errors++; $display("[TB] FAIL midrst_level_after got %0d want 1", LEVEL); end
  endtask

  task automatic test_random();
    int readyPct;
    applyReset();
    for (int c = 0; c < 600; c++) begin
      readyPct = ((c / 100) % 2 == 0) ? 15 : 70;
      applyStimulus($urandom_range(99) < 75, 4'($urandom), $urandom_range(99) < 3,
                    $urandom_range(99) < readyPct);
      checks += 3;
      if (LEVEL !== 3'(modelWords.size())) begin errors++; $display("[TB] FAIL rand_level c=%0d got %0d want %0d", c, LEVEL, modelWords.size()); end
      if (WORD_VALID !== (modelWords.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid c=%0d got %b want %b", c, WORD_VALID, modelWords.size() != 0); end
      if (OVERFLOW !== modelOvf) begin errors++; $display("[TB] FAIL rand_ovf c=%0d got %b want %b", c, OVERFLOW, modelOvf); end
      if (modelWords.size() != 0) begin
        checks++;
        if (WORD_OUT !== modelWords[0]) begin errors++; $display("[TB] FAIL rand_word c=%0d got %h want %h", c, WORD_OUT, modelWords[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_gaps_handshake();
    test_fill_overflow();
    test_full_push_pop();
    test_align();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Sits directly downstream of the nibble-selection stage.
- Accepts that stage's 4-bit DATA_OUT stream, one nibble per qualified cycle, and packs consecutive nibbles into 32-bit words.
- Completed words are buffered in a small show-ahead FIFO and delivered to the next consumer over a valid/ready handshake.
- The upstream stage has no back-pressure, so words that cannot be buffered are dropped and flagged.

Parameters:
- NIB_PER_WORD, 8, nibbles per output word; output word width = 4*NIB_PER_WORD.
- FIFO_DEPTH, 4, word entries in the output FIFO; must be a power of two.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- NIB_IN  input  4  nibble from the upstream selection stage.
- NIB_VALID  input  1  NIB_IN is sampled on this rising edge when high.
- ALIGN  input  1  synchronous; discards the partial word and restarts packing.
- WORD_OUT  output  32  FIFO head word; meaningful only while WORD_VALID=1.
- WORD_VALID  output  1  FIFO non-empty.
- WORD_READY  input  1  consumer accepts WORD_OUT this edge.
- LEVEL  output  ADDR_W+1  number of words in the FIFO, 0..FIFO_DEPTH.
- OVERFLOW  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (RESET_L=0, asynchronous):
  - WORD_OUT=0, WORD_VALID=0, LEVEL=0, OVERFLOW=0.
  - Pack counter=0, shift register=0, FIFO pointers=0.
  - Outputs hold these values until the first rising edge with RESET_L=1.
- Reset mid-operation: the partial word and all FIFO contents are discarded, with no partial output.

Packing:
- A nibble is accepted on every edge with NIB_VALID=1 and ALIGN=0.
- The first nibble of a word lands in [31:28]; each later nibble lands 4 bits lower; the 8th lands in [3:0]. Packing is MSN-first.
- The pack counter runs 0..NIB_PER_WORD-1, increments per accepted nibble, and wraps to 0 on the nibble that completes a word.
- NIB_VALID=0 holds the counter and shift register; gaps of any length are allowed.
- ALIGN=1 clears the counter and shift register, and overrides NIB_VALID on the same edge; the nibble on that edge is not accepted.

Push:
- On the edge that accepts the completing nibble, the assembled word (including that nibble) is pushed.
- Latency: completing nibble at edge k with the FIFO empty gives WORD_VALID=1 and WORD_OUT=word after edge k.

FIFO:
- Pop occurs when WORD_VALID=1 and WORD_READY=1 at an edge. WORD_READY while empty is ignored.
- Push while LEVEL<FIFO_DEPTH is stored at the tail.
- Push while LEVEL=FIFO_DEPTH with no pop on that edge: the word is dropped, OVERFLOW is set to 1 (held until reset), and LEVEL stays FIFO_DEPTH.
- Push and pop on the same edge when full: the pop frees a slot, the push is stored, LEVEL stays FIFO_DEPTH, OVERFLOW is unchanged.
- Push and pop on the same edge when not empty: LEVEL is unchanged and the head advances.
- Push to an empty FIFO with WORD_READY=1 on that edge: no pop occurs, because WORD_VALID was 0.
- Pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. LEVEL is a separate counter.
- WORD_OUT is always the head entry (show-ahead), with no extra read cycle.
- Ordering is strict FIFO; there is no reordering or duplication.

Test Plan:
- Basic pack: after reset release, NIB_IN=1,2,3,4,5,6,7,8 on 8 consecutive edges with WORD_READY=0. After the 8th edge: WORD_VALID=1, WORD_OUT=0x12345678, LEVEL=1.
- Gaps plus handshake: nibbles D,F,0,0,A,B,C,E with 2-cycle NIB_VALID gaps between them, then WORD_READY=1. Expect WORD_OUT=0xDF00ABCE; after the pop edge, WORD_VALID=0 and LEVEL=0.
- Fill and overflow: WORD_READY=0; push words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (LEVEL=4), then 0x55555555. Expect OVERFLOW=1 and LEVEL=4. With WORD_READY=1, drain in order 0x11111111..0x44444444; 0x55555555 never appears; OVERFLOW stays 1.
- Full with simultaneous push/pop: at LEVEL=4, raise WORD_READY=1 on the edge that completes 0x66666666. Expect LEVEL=4, OVERFLOW=0, and 0x66666666 as the last word of the drain.
- ALIGN: feed 3 nibbles 9,9,9, assert ALIGN for 1 cycle, then feed 8 nibbles 0..7. Expect a single word 0x01234567.
- Reset mid-operation: with LEVEL=2 and 5 nibbles packed, pulse RESET_L low asynchronously (not edge-aligned). Outputs go to 0 immediately; after release, 8 nibbles of F give 0xFFFFFFFF as the first word, with LEVEL=1.
